// File: rtl/cpu_io_pkg.sv
// Shared types and helpers for the CPU output-port path.
package cpu_io_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    HOLD
  } state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo
  import cpu_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/out_port_ctrl.sv
// Output-port sequencer: FIFO-buffered OUT writes, valid/ready port, hold time.
// Optional macro OUT_PORT_PASSTHRU_EN: zero-latency write when idle and empty.
module out_port_ctrl
  import cpu_io_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     out_we,
  input  logic [DATA_W-1:0]        out_data,
  output logic                     out_stall,
  output logic [DATA_W-1:0]        O_Port,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [cnt_w(DEPTH)-1:0]  fifo_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e            state_q;
  logic [DATA_W-1:0] port_q;
  logic              valid_q;
  logic              ovf_q;
  logic [HW-1:0]     hold_q;

  logic              bypass, push, pop;
  logic              full, empty;
  logic [DATA_W-1:0] head;

`ifdef OUT_PORT_PASSTHRU_EN
  assign bypass = (state_q == IDLE) && empty && out_we;
`else
  assign bypass = 1'b0;
`endif

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push = out_we && !full && !bypass;
  assign pop  = (state_q == IDLE) && !empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (out_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      port_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (out_we && full) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bypass) begin
            port_q  <= out_data;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end else if (pop) begin
            port_q  <= head;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (valid_q && o_ready) begin
            valid_q <= 1'b0;
            if (HOLD_CYCLES > 0) begin
              hold_q  <= HW'(HOLD_CYCLES - 1);
              state_q <= HOLD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) state_q <= IDLE;
          else              hold_q  <= hold_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign O_Port    = port_q;
  assign o_valid   = valid_q;
  assign overflow  = ovf_q;
  assign out_stall = full;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: doc/out_port_ctrl.md
Name: out_port_ctrl

Overview:
Sequencer for the CPU output port. Accepts OUT-instruction writes from the pipeline writeback stage and buffers them in a small FIFO. Presents each byte on O_Port with a valid/ready handshake to the external sink. Back-pressures the pipeline through out_stall when the buffer is full. Sits between the CPU core's writeback stage and the top-level O_Port pin of the CPU wrapper.

Parameters:
DATA_W, 8, port/data width in bits
DEPTH, 4, FIFO entries; power of two, at least 2
HOLD_CYCLES, 2, minimum cycles O_Port stays stable after an accepted handshake before the next pop; 0 = no hold

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
out_we  in  1  OUT instruction in writeback this cycle
out_data  in  DATA_W  register value to output
out_stall  out  1  FIFO full; pipeline must hold the OUT instruction
O_Port  out  DATA_W  output port value, registered, sticky
o_valid  out  1  O_Port holds a new, unacknowledged byte
o_ready  in  1  external sink accepts the byte
fifo_count  out  $clog2(DEPTH)+1  current occupancy
busy  out  1  FSM not IDLE or FIFO non-empty
overflow  out  1  sticky: a write arrived while full

Behaviour:
- Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset (async, any time, including mid-handshake or mid-hold):
  - O_Port=0, o_valid=0, fifo_count=0, overflow=0, busy=0, state=IDLE.
  - Pointers and hold counter are cleared. Buffered data is discarded.
- Push:
  - out_we=1 with fifo_count<DEPTH writes out_data at the rising edge.
  - out_we=1 with fifo_count==DEPTH drops the data and sets overflow, which stays set until reset.
  - A push while full is dropped even if a pop occurs in the same cycle.
- out_stall = (fifo_count==DEPTH), combinational from registered count.
- Simultaneous push and pop: count unchanged, both take effect.
- Pop while empty is impossible, because the FSM pops only when fifo_count!=0. A push into an empty FIFO is not bypassed; it is visible to the FSM the next cycle.
- Pointers wrap modulo DEPTH. Count saturates at neither end, because the guards above prevent it.
- FSM:
  - IDLE: if fifo_count!=0, pop the head into O_Port, set o_valid=1, go to PRESENT; else stay.
  - PRESENT: O_Port and o_valid held. When o_valid&&o_ready at an edge, clear o_valid. Then, if HOLD_CYCLES>0, load hold_cnt=HOLD_CYCLES-1 and go to HOLD; else go to IDLE.
  - HOLD: o_valid=0, O_Port held. Decrement hold_cnt. When hold_cnt==0 at the edge, go to IDLE.
- Latency, empty and idle: out_we at edge E0, then O_Port updates and o_valid rises after E1 (one cycle).
- Throughput with o_ready tied high: one byte per 2+HOLD_CYCLES cycles.
- O_Port is never cleared except by reset. It keeps the last byte indefinitely.

Optional Feature:
OUT_PORT_PASSTHRU_EN
- Defined: when state==IDLE, fifo_count==0 and out_we=1, out_data loads directly into O_Port with o_valid=1 at the same edge, and the FSM goes to PRESENT. The FIFO is not written. Latency becomes zero cycles after the write edge, matching legacy single-cycle port timing.
- Undefined: all writes go through the FIFO, with one-cycle latency as above.

Decomposition:
- Shared package cpu_io_pkg:
  - state enum (IDLE, PRESENT, HOLD)
  - DATA_W default constant
  - helper for count width
- One sub-module: sync_fifo (parameterised DATA_W/DEPTH; push/pop/full/empty/count; async active-low reset). The FSM, handshake and hold counter stay in out_port_ctrl.

Test Plan:
- Reset then single write, o_ready=1: out_we=1, out_data=0x55 at edge 1. O_Port=0x55 and o_valid=1 after edge 2; o_valid=0 after edge 3; O_Port stays 0x55 for 20 cycles.
- Burst of 5 writes (0x11..0x15), o_ready=0, DEPTH=4:
  - First byte moves to O_Port after 1 cycle. FIFO then fills with 0x12..0x15, out_stall=1 when count=4, overflow=0.
  - A 6th write while stalled sets overflow=1 and is lost.
- Drain ordering, o_ready=1, HOLD_CYCLES=2: bytes 0x11..0x15 appear in order, each new byte 4 cycles after the previous. out_stall drops after the first pop from full.
- Simultaneous push and pop at count=2: count stays 2, and the pushed byte appears after the two older ones.
- Assert rstn=0 asynchronously mid-HOLD with 3 entries queued: all outputs go to 0 immediately, before the next clock edge. After release, no stale bytes appear.
- With OUT_PORT_PASSTHRU_EN defined, empty and idle: write 0xA5. O_Port=0xA5 and o_valid=1 right after the write edge, and fifo_count stays 0.
